bloom_scan_ctrl: RTL and testbench

- Sequences the per-point reflector/blooming classification core over one frame of NUM_POINTS points held in the peak-data memory.
- Pass 1 (reflector scan): runs the core in reflector mode over every point, writes a fresh notation for each point and collects the distinct reflector distances.
- Passes 2..R+1 (bloom scans): one full blooming-mode scan per collected distance, read-modify-writing the notation memory.
- Sits between the frame memories and a single combinational core instance; a host starts it and waits for done.

---
 rtl/bloom_scan_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_bloom_scan_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bloom_scan_ctrl.sv
// bloom_scan_ctrl
//   Walks one frame of NUM_POINTS points through a single combinational
//   reflector/blooming classification core. Pass 1 runs the core in
//   reflector mode over every point, rewrites each notation and collects
//   distinct reflector distances. Each collected distance then gets its own
//   blooming-mode pass, which read-modify-writes the notation memory.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start / busy / done   host handshake (done is a one-cycle pulse)
//   ref_count             distances stored this frame
//   ref_overflow          a new distance was dropped because the table was full
//   bloom_count           points newly marked 01 this frame
//   mem_rd_en, mem_addr   shared read port of the peak and notation memories
//   mem_rdata, not_rdata  read data, one cycle after mem_rd_en
//   not_wr_en/waddr/wdata notation write port
//   core_*                connections to the classification core
module bloom_scan_ctrl #(
  parameter int SIGNAL_WIDTH = 18,
  parameter int DIST_WIDTH   = 14,
  parameter int NOT_WIDTH    = 2,
  parameter int PEAK_NUM     = 4,
  parameter int DATA_WIDTH   = (SIGNAL_WIDTH + DIST_WIDTH) * PEAK_NUM,
  parameter int NUM_POINTS   = 1024,
  parameter int ADDR_WIDTH   = 10,
  parameter int MAX_REF      = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(MAX_REF+1)-1:0]   ref_count,
  output logic                           ref_overflow,
  output logic [ADDR_WIDTH:0]            bloom_count,
  output logic                           mem_rd_en,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  input  logic [NOT_WIDTH-1:0]           not_rdata,
  output logic                           not_wr_en,
  output logic [ADDR_WIDTH-1:0]          not_waddr,
  output logic [NOT_WIDTH-1:0]           not_wdata,
  output logic                           core_ref_mode,
  output logic                           core_blooming_mode,
  output logic [DATA_WIDTH-1:0]          core_mem_data,
  output logic [DIST_WIDTH-1:0]          core_distance,
  output logic [NOT_WIDTH-1:0]           core_point_notation_i,
  input  logic [NOT_WIDTH-1:0]           core_point_notation_o,
  input  logic                           core_has_ref,
  input  logic [DIST_WIDTH-1:0]          core_ref_dist,
  input  logic                           core_is_bloom
);

  localparam int CNT_W     = $clog2(MAX_REF + 1);
  // Table is sized to the full index range so the count can address it directly.
  localparam int TBL_DEPTH = 1 << CNT_W;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_POINTS - 1);

  typedef enum logic [1:0] {IDLE, REF_SCAN, BLOOM_SCAN, DONE} state_t;

  state_t                 state;
  logic [DIST_WIDTH-1:0]  ref_table [TBL_DEPTH];
  logic [CNT_W-1:0]       tbl_idx;
  logic [DIST_WIDTH-1:0]  last_dist;
  logic                   eval;       // evaluate cycle: read data for eval_addr is present
  logic [ADDR_WIDTH-1:0]  eval_addr;

  logic                   last_eval;
  logic                   ref_new;
  logic                   ref_push;
  logic                   bloom_hit;
  logic [CNT_W-1:0]       ref_count_next;
  logic [CNT_W-1:0]       next_idx;
  logic [DIST_WIDTH-1:0]  first_dist;

  // Bloom accounting keys off the 00 -> 01 notation transition so a point
  // already marked by an earlier pass is never counted twice; the core's own
  // hit flag is therefore informational only.
  logic unused_is_bloom;
  assign unused_is_bloom = core_is_bloom;

  assign core_ref_mode         = eval && (state == REF_SCAN);
  assign core_blooming_mode    = eval && (state == BLOOM_SCAN);
  assign core_mem_data         = eval ? mem_rdata : '0;
  assign core_point_notation_i = eval ? not_rdata : '0;
  assign not_wr_en             = eval;
  assign not_waddr             = eval_addr;
  assign not_wdata             = eval ? core_point_notation_o : '0;

  assign last_eval = eval && (eval_addr == LAST_ADDR);

  // Consecutive de-duplication against the most recently stored distance.
  assign ref_new  = core_ref_mode && core_has_ref &&
                    ((ref_count == '0) || (core_ref_dist != last_dist));
  assign ref_push = ref_new && (ref_count < CNT_W'(MAX_REF));
  assign ref_count_next = ref_count + CNT_W'(ref_push);

  assign bloom_hit = core_blooming_mode && (not_rdata == '0) &&
                     (core_point_notation_o == NOT_WIDTH'(1));

  assign next_idx = tbl_idx + CNT_W'(1);

  // The first distance may be pushed on the very last reflector evaluate,
  // i.e. on the same edge that loads it into core_distance.
  assign first_dist = (ref_push && ref_count == '0) ? core_ref_dist : ref_table[0];

  always_ff @(posedge clk) begin
    if (ref_push) begin
      ref_table[ref_count] <= core_ref_dist;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      ref_count     <= '0;
      ref_overflow  <= 1'b0;
      bloom_count   <= '0;
      mem_rd_en     <= 1'b0;
      mem_addr      <= '0;
      eval          <= 1'b0;
      eval_addr     <= '0;
      tbl_idx       <= '0;
      last_dist     <= '0;
      core_distance <= '0;
    end else begin
      done      <= 1'b0;
      eval      <= mem_rd_en;
      eval_addr <= mem_addr;

      if (mem_rd_en) begin
        if (mem_addr == LAST_ADDR) begin
          mem_rd_en <= 1'b0;
        end else begin
          mem_addr <= mem_addr + ADDR_WIDTH'(1);
        end
      end

      if (ref_push) begin
        ref_count <= ref_count_next;
        last_dist <= core_ref_dist;
      end else if (ref_new) begin
        ref_overflow <= 1'b1;
      end

      if (bloom_hit && (bloom_count < (ADDR_WIDTH+1)'(NUM_POINTS))) begin
        bloom_count <= bloom_count + (ADDR_WIDTH+1)'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            state         <= REF_SCAN;
            busy          <= 1'b1;
            ref_count     <= '0;
            ref_overflow  <= 1'b0;
            bloom_count   <= '0;
            tbl_idx       <= '0;
            core_distance <= '0;
            mem_rd_en     <= 1'b1;
            mem_addr      <= '0;
          end
        end
        REF_SCAN: begin
          if (last_eval) begin
            if (ref_count_next == '0) begin
              state <= DONE;
            end else begin
              state         <= BLOOM_SCAN;
              tbl_idx       <= '0;
              core_distance <= first_dist;
              mem_rd_en     <= 1'b1;
              mem_addr      <= '0;
            end
          end
        end
        BLOOM_SCAN: begin
          if (last_eval) begin
            if (next_idx < ref_count) begin
              tbl_idx       <= next_idx;
              core_distance <= ref_table[next_idx];
              mem_rd_en     <= 1'b1;
              mem_addr      <= '0;
            end else begin
              state         <= DONE;
              core_distance <= '0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bloom_scan_ctrl.sv
module tb_bloom_scan_ctrl;

  localparam int S  = 18;
  localparam int D  = 14;
  localparam int NW = 2;
  localparam int PN = 4;
  localparam int PW = S + D;
  localparam int DW = PW * PN;
  localparam int NP = 8;
  localparam int AW = 3;
  localparam int MR = 2;
  localparam int CW = $clog2(MR + 1);
  localparam int THRESH = 1 << 17;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy, done;
  logic [CW-1:0] ref_count;
  logic ref_overflow;
  logic [AW:0] bloom_count;
  logic mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [NW-1:0] not_rdata;
  logic not_wr_en;
  logic [AW-1:0] not_waddr;
  logic [NW-1:0] not_wdata;
  logic core_ref_mode, core_blooming_mode;
  logic [DW-1:0] core_mem_data;
  logic [D-1:0] core_distance;
  logic [NW-1:0] core_point_notation_i, core_point_notation_o;
  logic core_has_ref;
  logic [D-1:0] core_ref_dist;
  logic core_is_bloom;

  always #5 clk = ~clk;

  bloom_scan_ctrl #(
    .SIGNAL_WIDTH(S), .DIST_WIDTH(D), .NOT_WIDTH(NW), .PEAK_NUM(PN),
    .DATA_WIDTH(DW), .NUM_POINTS(NP), .ADDR_WIDTH(AW), .MAX_REF(MR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .ref_count(ref_count), .ref_overflow(ref_overflow), .bloom_count(bloom_count),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .not_rdata(not_rdata), .not_wr_en(not_wr_en), .not_waddr(not_waddr),
    .not_wdata(not_wdata), .core_ref_mode(core_ref_mode),
    .core_blooming_mode(core_blooming_mode), .core_mem_data(core_mem_data),
    .core_distance(core_distance), .core_point_notation_i(core_point_notation_i),
    .core_point_notation_o(core_point_notation_o), .core_has_ref(core_has_ref),
    .core_ref_dist(core_ref_dist), .core_is_bloom(core_is_bloom)
  );

  // Frame memories: read-old-data on same-address read/write.
  logic [DW-1:0] pk [NP];
  logic [NW-1:0] nt [NP];
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata <= pk[mem_addr];
      not_rdata <= nt[mem_addr];
    end
    if (not_wr_en) nt[not_waddr] <= not_wdata;
  end

  // Classification core: reflector = first peak with amplitude >= THRESH;
  // bloom = an unmarked point with any peak at the target distance.
  always_comb begin
    core_point_notation_o = core_point_notation_i;
    core_has_ref  = 1'b0;
    core_ref_dist = '0;
    core_is_bloom = 1'b0;
    if (core_ref_mode) begin
      for (int k = PN - 1; k >= 0; k--) begin
        if (core_mem_data[k*PW+D +: S] >= S'(THRESH)) begin
          core_has_ref  = 1'b1;
          core_ref_dist = core_mem_data[k*PW +: D];
        end
      end
      core_point_notation_o = core_has_ref ? 2'b10 : 2'b00;
    end else if (core_blooming_mode) begin
      for (int k = 0; k < PN; k++) begin
        if (core_point_notation_i == 2'b00 && core_mem_data[k*PW +: D] == core_distance) begin
          core_is_bloom = 1'b1;
        end
      end
      if (core_is_bloom) core_point_notation_o = 2'b01;
    end
  end

  // Frame contents as plain integers; packed into pk before each start.
  int amp_a [NP][PN];
  int dist_a [NP][PN];

  typedef struct {
    int refc;
    int ovf;
    int bloom;
    int nts;
    int lat;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int frames_done = 0;
  logic prev_rd_en = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic exp_t model();
    exp_t e;
    int tbl[$];
    int n[NP];
    int refd;
    bit hit;
    e.ovf = 0;
    e.bloom = 0;
    for (int p = 0; p < NP; p++) begin
      refd = -1;
      for (int k = 0; k < PN; k++)
        if (refd < 0 && amp_a[p][k] >= THRESH) refd = dist_a[p][k];
      n[p] = (refd >= 0) ? 2 : 0;
      if (refd >= 0 && (tbl.size() == 0 || tbl[tbl.size()-1] != refd)) begin
        if (tbl.size() < MR) tbl.push_back(refd);
        else e.ovf = 1;
      end
    end
    foreach (tbl[i]) begin
      for (int p = 0; p < NP; p++) begin
        hit = 0;
        for (int k = 0; k < PN; k++) if (dist_a[p][k] == tbl[i]) hit = 1;
        if (n[p] == 0 && hit) begin
          n[p] = 1;
          e.bloom++;
        end
      end
    end
    e.refc = tbl.size();
    e.nts = 0;
    for (int p = 0; p < NP; p++) e.nts = e.nts | (n[p] << (2 * p));
    e.lat = (1 + tbl.size()) * (NP + 1) + 1;
    return e;
  endfunction

  // Monitor: pipeline sanity every cycle, frame results on each done pulse.
  always @(negedge clk) begin
    exp_t e;
    int act_nts;
    cyc++;
    if (!rst) begin
      if (not_wr_en || core_ref_mode || core_blooming_mode) begin
        chk("wr_en_vs_mode", int'(not_wr_en), int'(core_ref_mode ^ core_blooming_mode));
      end
      if (not_wr_en) begin
        chk("waddr_follows_issue", int'(not_waddr), int'(prev_addr));
        chk("write_after_read", int'(prev_rd_en), 1);
      end
      if (start && !busy) start_cyc = cyc;
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          last_exp = e;
          act_nts = 0;
          for (int p = 0; p < NP; p++) act_nts = act_nts | (int'(nt[p]) << (2 * p));
          chk("ref_count", int'(ref_count), e.refc);
          chk("ref_overflow", int'(ref_overflow), e.ovf);
          chk("bloom_count", int'(bloom_count), e.bloom);
          chk("notations", act_nts, e.nts);
          chk("latency", cyc - start_cyc - 1, e.lat);
          chk("busy_at_done", int'(busy), 0);
          $display("frame %0d: refs=%0d ovf=%0d bloom=%0d nts=%04h lat=%0d", frames_done,
                   ref_count, ref_overflow, bloom_count, act_nts, cyc - start_cyc - 1);
        end
        frames_done++;
      end
    end
    prev_rd_en = mem_rd_en;
    prev_addr  = mem_addr;
  end

  task automatic clear_frame();
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < PN; k++) begin
        amp_a[p][k]  = 10 + p;
        dist_a[p][k] = 1000 + p * PN + k;
      end
  endtask

  task automatic rand_frame();
    int pool[4] = '{50, 70, 90, 110};
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < PN; k++) begin
        amp_a[p][k]  = ($urandom_range(0, 5) == 0) ? THRESH + int'($urandom_range(0, 1000))
                                                   : int'($urandom_range(0, THRESH - 1));
        dist_a[p][k] = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)]
                                                   : int'($urandom_range(200, 16383));
      end
  endtask

  task automatic load_and_start(input int busy_poke);
    logic [DW-1:0] w;
    for (int p = 0; p < NP; p++) begin
      w = '0;
      for (int k = 0; k < PN; k++) begin
        w[k*PW +: D]   = D'(dist_a[p][k]);
        w[k*PW+D +: S] = S'(amp_a[p][k]);
      end
      pk[p] = w;
    end
    sb.push_back(model());
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (busy_poke > 0) begin
      repeat (busy_poke) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
  endtask

  task automatic wait_done();
    int target = frames_done + 1;
    int n = 0;
    while (frames_done < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (frames_done < target) chk("done_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mem_rdata = '0;
    not_rdata = '0;
    for (int p = 0; p < NP; p++) nt[p] = NW'($urandom_range(0, 3));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_ref_count", int'(ref_count), 0);
    chk("reset_bloom_count", int'(bloom_count), 0);
    chk("reset_overflow", int'(ref_overflow), 0);
    chk("reset_rd_en", int'(mem_rd_en), 0);
    chk("reset_modes", int'({core_ref_mode, core_blooming_mode, not_wr_en}), 0);

    // No reflectors at all.
    clear_frame();
    load_and_start(0);
    wait_done();

    // Reflector at point 3 (distance 100), blooming peaks at points 5 and 6.
    clear_frame();
    amp_a[3][1] = THRESH + 5; dist_a[3][1] = 100;
    dist_a[5][0] = 100;
    dist_a[6][3] = 100;
    load_and_start(0);
    wait_done();
    repeat (3) @(negedge clk);
    chk("hold_ref_count", int'(ref_count), last_exp.refc);
    chk("hold_bloom_count", int'(bloom_count), last_exp.bloom);

    // Duplicate distance 50 at points 1,2 and 70 at point 4; point 6 holds both.
    clear_frame();
    amp_a[1][0] = THRESH; dist_a[1][0] = 50;
    amp_a[2][2] = THRESH + 9; dist_a[2][2] = 50;
    amp_a[4][1] = THRESH + 1; dist_a[4][1] = 70;
    dist_a[6][0] = 50; dist_a[6][1] = 70;
    dist_a[7][2] = 70;
    load_and_start(0);
    wait_done();

    // Three distinct distances against a two-entry table.
    clear_frame();
    amp_a[0][0] = THRESH; dist_a[0][0] = 50;
    amp_a[2][1] = THRESH; dist_a[2][1] = 70;
    amp_a[5][3] = THRESH; dist_a[5][3] = 90;
    dist_a[1][2] = 50; dist_a[6][0] = 70; dist_a[7][1] = 90;
    load_and_start(0);
    wait_done();
    repeat (2) @(negedge clk);
    chk("hold_overflow", int'(ref_overflow), last_exp.ovf);

    // start pulsed mid-frame must not disturb the pass count.
    clear_frame();
    amp_a[3][1] = THRESH + 5; dist_a[3][1] = 100;
    dist_a[5][0] = 100;
    load_and_start(6);
    wait_done();

    // Reset in the middle of the bloom pass.
    clear_frame();
    amp_a[3][1] = THRESH + 5; dist_a[3][1] = 100;
    dist_a[5][0] = 100;
    load_and_start(0);
    repeat (12) @(posedge clk);
    #1 rst = 1'b1;
    void'(sb.pop_front());
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_enables", int'({mem_rd_en, not_wr_en, core_ref_mode, core_blooming_mode}), 0);
    chk("abort_counters", int'(ref_count) + int'(bloom_count) + int'(ref_overflow), 0);
    repeat (30) @(negedge clk);
    chk("abort_no_done", frames_done, 5);

    for (int i = 0; i < 25; i++) begin
      rand_frame();
      load_and_start(0);
      wait_done();
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
